gbfflgofm_rd_ctrl: RTL and testbench

Read-side controller for the OFM flag global buffer. On a start command it drains a run of `word_num` words from the single-port flag SRAM, beginning at `base_addr` and wrapping modulo depth. It accounts for the SRAM's 1-cycle read latency and yields the port to the write side whenever that side is writing. Data leaves on a valid/ready stream through a 2-entry output FIFO, so backpressure never loses a word and an unstalled run sustains 1 word/cycle.

---
 rtl/gbfflgofm_rd_ctrl.sv | 125 ++++++++++++
 tb/tb_gbfflgofm_rd_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbfflgofm_rd_ctrl.sv
// Read-side controller for the OFM flag global buffer: drains word_num words
// from the flag SRAM starting at base_addr (wrapping), yielding to writes.
// Ports: clk/rst; start, base_addr, word_num -> busy, done;
//        SRAM: ram_write_en in, ram_read_en/ram_addr_r out, ram_data_out in;
//        stream: out_valid/out_data out, out_ready in (2-entry FIFO behind it).
module gbfflgofm_rd_ctrl #(
   parameter int SRAM_DEPTH_BIT = 6,
   parameter int SRAM_WIDTH     = 28
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [SRAM_DEPTH_BIT-1:0] base_addr,
   input  logic [SRAM_DEPTH_BIT:0]   word_num,
   output logic                      busy,
   output logic                      done,
   input  logic                      ram_write_en,
   output logic                      ram_read_en,
   output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
   input  logic [SRAM_WIDTH-1:0]     ram_data_out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SRAM_WIDTH-1:0]     out_data
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [SRAM_DEPTH_BIT:0] CNT_ONE = 1;

   state_t                      state;
   logic [SRAM_DEPTH_BIT-1:0]   ptr;
   logic [SRAM_DEPTH_BIT:0]     issue_cnt;
   logic [SRAM_DEPTH_BIT:0]     pop_cnt;
   logic                        pend;
   logic                        done_r;
   logic [SRAM_WIDTH-1:0]       fifo_mem [2];
   logic                        wr_ptr;
   logic                        rd_ptr;
   logic [1:0]                  fifo_cnt;

   logic                        pop;
   logic                        issue;
   logic [2:0]                  occ;

   assign pop = (fifo_cnt != 2'd0) && out_ready;

   // Slots committed for the next cycle: words held, plus the word landing
   // from last cycle's read, minus the one leaving now. A new read is only
   // allowed if its data is guaranteed a FIFO slot when it returns.
   assign occ   = {1'b0, fifo_cnt} + {2'b00, pend} - {2'b00, pop};
   assign issue = (state == READ) && !ram_write_en && (occ < 3'd2);

   assign ram_read_en = issue;
   assign ram_addr_r  = ptr;
   assign out_valid   = (fifo_cnt != 2'd0);
   assign out_data    = fifo_mem[rd_ptr];
   assign busy        = (state != IDLE);
   assign done        = done_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         issue_cnt   <= '0;
         pop_cnt     <= '0;
         pend        <= 1'b0;
         done_r      <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
      end else begin
         done_r <= 1'b0;
         pend   <= issue;

         if (pend) begin
            fifo_mem[wr_ptr] <= ram_data_out;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= fifo_cnt + {1'b0, pend} - {1'b0, pop};

         unique case (state)
            IDLE: begin
               if (start) begin
                  if (word_num != '0) begin
                     ptr       <= base_addr;
                     issue_cnt <= word_num;
                     pop_cnt   <= word_num;
                     state     <= READ;
                  end else begin
                     done_r <= 1'b1;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  ptr       <= ptr + 1'b1;
                  issue_cnt <= issue_cnt - CNT_ONE;
                  if (issue_cnt == CNT_ONE) begin
                     state <= DRAIN;
                  end
               end
               if (pop) begin
                  pop_cnt <= pop_cnt - CNT_ONE;
               end
            end
            DRAIN: begin
               if (pop) begin
                  pop_cnt <= pop_cnt - CNT_ONE;
                  if (pop_cnt == CNT_ONE) begin
                     state  <= IDLE;
                     done_r <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gbfflgofm_rd_ctrl.sv
// Bench for gbfflgofm_rd_ctrl: directed scenarios plus randomized runs,
// checked by a queue scoreboard fed from a run-level reference model.
module tb_gbfflgofm_rd_ctrl;

   localparam int DB    = 6;
   localparam int W     = 28;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DB-1:0] base_addr;
   logic [DB:0]   word_num;
   logic          busy;
   logic          done;
   logic          ram_write_en;
   logic          ram_read_en;
   logic [DB-1:0] ram_addr_r;
   logic [W-1:0]  ram_data_out;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;

   always #5 clk = ~clk;

   gbfflgofm_rd_ctrl #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .word_num(word_num), .busy(busy), .done(done),
      .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
      .ram_addr_r(ram_addr_r), .ram_data_out(ram_data_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   logic [W-1:0] mem [DEPTH];
   initial ram_data_out = '0;
   always @(posedge clk) if (ram_read_en) ram_data_out <= mem[ram_addr_r];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;

   logic [W-1:0]  exp_q [$];
   logic [DB-1:0] addr_q [$];
   int            done_q [$];
   int            outstanding = 0;
   bit            model_busy = 0;
   int            run_start = 0;
   int            start_cyc = 0;
   int            first_valid = -1;
   int            last_done = -1;
   bit            chk_rst = 0;
   bit            stall_prev = 0;
   logic [W-1:0]  stall_data;
   bit            rand_en = 0;
   bit            rand_done = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: sees settled values mid-cycle, i.e. what the next edge commits.
   always @(negedge clk) begin
      bit de;
      bit hs;
      if (rst) begin
         exp_q.delete();
         addr_q.delete();
         done_q.delete();
         outstanding = 0;
         model_busy  = 0;
         stall_prev  = 0;
         chk_rst     = 1;
      end else begin
         hs = out_valid && out_ready;
         if (chk_rst) begin
            check("reset_ctrl",
                  32'({busy, done, ram_read_en, out_valid, ram_addr_r}), 0);
            check("reset_data", 32'(out_data), 0);
            chk_rst = 0;
         end
         if (model_busy && cyc > run_start) check("busy_in_run", 32'(busy), 1);
         de = 0;
         while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
         if (done_q.size() > 0 && done_q[0] == cyc) begin
            de = 1;
            void'(done_q.pop_front());
         end
         if (done || de) begin
            check("done_timing", 32'(done), 32'(de));
            if (done) check("busy_at_done", 32'(busy), 0);
         end
         if (done) last_done = cyc;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (stall_prev) check("stall_hold", 32'({out_valid, out_data}),
                               32'({1'b1, stall_data}));
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
         if (ram_read_en) begin
            check("read_vs_write", 32'(ram_write_en), 0);
            check("occupancy_lt2", 32'((outstanding - int'(hs)) < 2), 1);
            if (addr_q.size() == 0) check("read_unexpected", 32'(ram_read_en), 0);
            else check("read_addr", 32'(ram_addr_r), 32'(addr_q.pop_front()));
            outstanding++;
         end
         if (hs) begin
            if (exp_q.size() == 0) check("word_unexpected", 32'(out_valid), 0);
            else check("word", 32'(out_data), 32'(exp_q.pop_front()));
            outstanding--;
            if (exp_q.size() == 0 && model_busy) begin
               model_busy = 0;
               done_q.push_back(cyc + 1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model of a run: the exact address and word sequence it emits.
   task automatic start_run(input int b, input int n);
      start     = 1'b1;
      base_addr = DB'(b);
      word_num  = (DB+1)'(n);
      if (!model_busy) begin
         start_cyc = cyc;
         if (n == 0) begin
            done_q.push_back(cyc + 1);
         end else begin
            for (int i = 0; i < n; i++) begin
               exp_q.push_back(mem[(b + i) % DEPTH]);
               addr_q.push_back(DB'((b + i) % DEPTH));
            end
            model_busy  = 1;
            run_start   = cyc;
            first_valid = -1;
         end
      end
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while (model_busy && k < limit) begin
         tick();
         k++;
      end
      if (model_busy) begin
         n_cmp++;
         n_fail++;
         $display("FAIL run_timeout: busy %0b after %0d cycles, %0d words left",
                  busy, limit, exp_q.size());
         rst = 1'b1;
         tick();
         rst = 1'b0;
      end
   endtask

   initial begin
      int s;
      int pat [6] = '{1, 0, 0, 1, 0, 1};
      fork
         while (!rand_done) begin
            @(posedge clk);
            #1;
            if (rand_en) begin
               out_ready    = ($urandom_range(0, 3) != 0);
               ram_write_en = ($urandom_range(0, 3) == 0);
            end
         end
      join_none

      rst = 1'b1; start = 1'b0; base_addr = '0; word_num = '0;
      ram_write_en = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = W'(i + 'h100);
      tick(); tick();
      rst = 1'b0;
      tick();

      start_run(4, 8);
      s = start_cyc;
      wait_idle(100);
      tick();
      check("basic_first_valid", 32'(first_valid), 32'(s + 3));
      check("basic_done_cycle", 32'(last_done), 32'(s + 11));

      start_run(62, 4);
      wait_idle(100);
      tick();

      start_run(0, 6);
      for (int k = 0; model_busy && k < 200; k++) begin
         out_ready = pat[k % 6] != 0;
         tick();
      end
      out_ready = 1'b1;
      wait_idle(50);
      tick();

      start_run(7, 5);
      s = start_cyc;
      tick();
      ram_write_en = 1'b1;
      tick(); tick(); tick();
      ram_write_en = 1'b0;
      wait_idle(100);
      tick();
      check("wrconf_done_cycle", 32'(last_done), 32'(s + 11));

      start_run(5, 0);
      s = start_cyc;
      tick(); tick();
      check("zero_done_cycle", 32'(last_done), 32'(s + 1));

      start_run(20, 6);
      start = 1'b1; base_addr = 6'd40; word_num = 7'd3;
      tick(); tick();
      start = 1'b0;
      wait_idle(100);
      tick();

      start_run(30, 8);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      start_run(10, 2);
      wait_idle(100);
      tick(); tick();
      check("queue_drained", 32'(exp_q.size()), 0);

      for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
      rand_en = 1;
      for (int r = 0; r < 40; r++) begin
         int n;
         n = (r % 8 == 3) ? 0 : int'($urandom_range(1, DEPTH));
         start_run(int'($urandom_range(0, DEPTH - 1)), n);
         if (n != 0 && $urandom_range(0, 1) == 1) begin
            start = 1'b1;
            base_addr = DB'($urandom);
            word_num = 7'd5;
            tick();
            start = 1'b0;
         end
         wait_idle(2000);
      end
      rand_en = 0;
      rand_done = 1;
      out_ready = 1'b1;
      ram_write_en = 1'b0;
      repeat (5) tick();
      check("final_queue_drained", 32'(exp_q.size()), 0);
      check("final_idle", 32'({busy, out_valid}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
